// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC and the 16-entry jump-target LUT, resolves decoder branches.
// Optional build macro RELATIVE_BRANCH_EN: LUT entries become signed PC-relative offsets instead of absolute targets.
module fetch_sequencer #(
   parameter int              PC_W       = 10,
   parameter logic [PC_W-1:0] START_ADDR = {PC_W{1'b0}},
   parameter logic [PC_W-1:0] END_ADDR   = {PC_W{1'b1}}
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            start,
   input  logic            stall,
   input  logic [1:0]      branch,
   input  logic [3:0]      target_lut,
   input  logic            cond,
   input  logic            lut_we,
   input  logic [3:0]      lut_waddr,
   input  logic [PC_W-1:0] lut_wdata,
   output logic [PC_W-1:0] pc,
   output logic            running,
   output logic            taken,
   output logic            done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] lut_q [16];
   logic            cond_hit_s;
   logic            taken_s;
   logic [PC_W-1:0] branch_tgt_s;

   // Branch target: read of the registered LUT, so a same-cycle write is not yet visible.
`ifdef RELATIVE_BRANCH_EN
   assign branch_tgt_s = pc_q + lut_q[target_lut];
`else
   assign branch_tgt_s = lut_q[target_lut];
`endif

   // Branch decision and next-state / next-PC selection.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      cond_hit_s = 1'b0;
      case (branch)
         2'b11:   cond_hit_s = 1'b1;
         2'b01:   cond_hit_s = cond;
         2'b10:   cond_hit_s = ~cond;
         default: cond_hit_s = 1'b0;
      endcase
      taken_s = (state_q == ST_RUN) && !stall && cond_hit_s;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_RUN;
               pc_d    = START_ADDR;
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (stall) begin
               pc_d = pc_q;
            end else if (pc_q == END_ADDR) begin
               state_d = ST_DONE;
            end else if (taken_s) begin
               pc_d = branch_tgt_s;
            end else begin
               pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = {PC_W{1'b0}};
         end
      endcase
   end

   // State and program counter registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         pc_q    <= {PC_W{1'b0}};
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Jump-target LUT, writable in every state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < 16; i++) begin
            lut_q[i] <= {PC_W{1'b0}};
         end
      end else if (lut_we) begin
         lut_q[lut_waddr] <= lut_wdata;
      end else begin
         lut_q[lut_waddr] <= lut_q[lut_waddr];
      end
   end

   assign pc      = pc_q;
   assign running = (state_q == ST_RUN);
   assign done    = (state_q == ST_DONE);
   assign taken   = taken_s;

endmodule
